id_ex_reg: RTL and testbench
============================

# id_ex_reg

ID/EX pipeline register for the LEGv8 five-stage core. Captures decode-stage operands, immediate, register indices and the control bundle at the end of ID, and presents them to EX. Also detects load-use hazards against the instruction currently in EX, stalls PC and IF/ID, and injects a one-cycle bubble. Optionally forwards the same-cycle write-back value around the register file, which writes on the clock edge.

## Interface
- WORD, 64: datapath width; matches the core word size.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  branch taken in EX/MEM; squash the ID instruction
- hold  in  1  global pipeline freeze from the memory stage
- id_valid  in  1  ID holds a real instruction
- id_pc  in  WORD  PC of the ID instruction
- id_rdata1, id_rdata2  in  WORD  register file read data
- id_imm  in  WORD  sign-extended immediate
- id_rn, id_rm, id_rd  in  5  source and destination indices
- id_use_rn, id_use_rm  in  1  instruction actually reads Rn / Rm
- id_ctrl  in  CTRL_W  control bundle from the decoder
- wb_regwrite  in  1  write-back enable (bypass path)
- wb_rd  in  5  write-back destination index (bypass path)
- wb_data  in  WORD  write-back data (bypass path)
- ex_valid  out  1  registered id_valid
- ex_pc, ex_rdata1, ex_rdata2, ex_imm  out  WORD  registered fields
- ex_rn, ex_rm, ex_rd  out  5  registered indices
- ex_ctrl  out  CTRL_W  registered control bundle
- stall  out  1  combinational; freeze PC and IF/ID this cycle
- bubble_cnt  out  32  saturating count of inserted load-use bubbles

## Operation
- Reset value of every output is 0, including stall and bubble_cnt.
- Load-use detection, combinational:
  - lu = ex_valid & ex_ctrl.MemRead & (ex_rd != 31) & id_valid & ((id_use_rn & ex_rd == id_rn) | (id_use_rm & ex_rd == id_rm))
  - stall = lu & ~flush.
- Per-edge update priority:
  1. flush: load a bubble, even when hold is asserted.
  2. hold: all ex_* keep their values; bubble_cnt unchanged.
  3. lu: load a bubble; bubble_cnt += 1, saturating at 0xFFFF_FFFF.
  4. Otherwise: capture all id_* fields.
- Bubble: ex_valid=0, ex_ctrl=0, ex_rd=31. Data fields may keep their old values, but must never drive writes.
- Register 31 (XZR) never creates a hazard and is never bypassed.
- Field widths are passed through unchanged; there is no arithmetic other than bubble_cnt.

## Timing
- Latency: 1 cycle from ID to EX.
- stall is valid in the same cycle as the offending ID instruction. The ID instruction is re-presented next cycle and is captured then, because the bubble has cleared lu.
- Simultaneous flush and lu: flush wins, stall=0, and bubble_cnt is not incremented.
- Simultaneous hold and lu: stall=1, registers hold.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first capture happens on the first edge after deassertion.

## Configuration
- LEGV8_WB_BYPASS_EN defined:
  - Captured rdata1 = wb_data when wb_regwrite & wb_rd == id_rn & wb_rd != 31; otherwise id_rdata1.
  - Captured rdata2 uses the same rule against id_rm.
- LEGV8_WB_BYPASS_EN undefined:
  - The wb_* ports are ignored; id_rdata1/2 are captured raw.
  - Software or forwarding must cover the WB→ID gap.

## Structure
- Shared package/header (common.vh) holds:
  - CTRL_W=9
  - Control bit positions: RegWrite[0], MemRead[1], MemWrite[2], MemtoReg[3], ALUSrc[4], ALUOp[6:5], Branch[7], Uncond[8]
  - XZR_IDX=31
- One natural sub-module: hazard_detect, the combinational load-use comparator producing lu. The register, bypass muxes and counter stay in id_ex_reg.

## Test plan
- Normal flow: id_pc=0x100, rdata1=0xA, ctrl=0x011, no hazard → next cycle ex_pc=0x100, ex_rdata1=0xA, ex_ctrl=0x011, stall=0.
- Load-use: EX holds LDUR with rd=5; ID uses rn=5 → stall=1, next ex_ctrl=0 and ex_valid=0, bubble_cnt=1; the following cycle captures the ID instruction.
- XZR: EX LDUR with rd=31, ID rn=31 → stall=0, no bubble.
- Flush with lu: both asserted → stall=0, bubble loaded, bubble_cnt unchanged; flush during hold still clears ex_ctrl.
- Bypass (macro on): wb_regwrite=1, wb_rd=3, wb_data=0xDEAD, id_rn=3, id_rdata1=0x1 → ex_rdata1=0xDEAD. With wb_rd=31 or the macro off → ex_rdata1=0x1.
- Async reset while ex_valid=1 and bubble_cnt=7 → all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_reg_pkg.sv
// Shared types, widths and control-bundle bit positions for the LEGv8 ID/EX stage.
package id_ex_reg_pkg;

  localparam int WORD   = 64;
  localparam int CTRL_W = 9;
  localparam int REG_W  = 5;

  localparam logic [REG_W-1:0] XZR_IDX = 5'd31;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_ALUOP_LO = 5;
  localparam int CTRL_ALUOP_HI = 6;
  localparam int CTRL_BRANCH   = 7;
  localparam int CTRL_UNCOND   = 8;

  typedef logic [WORD-1:0]   word_t;
  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef struct packed {
    logic     valid;
    word_t    pc;
    word_t    rdata1;
    word_t    rdata2;
    word_t    imm;
    reg_idx_t rn;
    reg_idx_t rm;
    reg_idx_t rd;
    ctrl_t    ctrl;
  } ex_bundle_t;

  function automatic logic is_xzr(input reg_idx_t idx);
    return idx == XZR_IDX;
  endfunction

  // XZR reads as zero and discards writes, so it never matches anything.
  function automatic logic idx_match(input reg_idx_t a, input reg_idx_t b);
    return !is_xzr(a) && (a == b);
  endfunction

  // A bubble keeps the data fields but cannot write anything.
  function automatic ex_bundle_t bubble_of(input ex_bundle_t cur);
    ex_bundle_t b;
    b       = cur;
    b.valid = 1'b0;
    b.ctrl  = '0;
    b.rd    = XZR_IDX;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_reg_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds the ID instruction.
module hazard_detect
  import id_ex_reg_pkg::*;
(
  input  logic           ex_valid,
  input  logic           ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic           id_valid,
  input  logic           id_use_rn,
  input  logic           id_use_rm,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  output logic           lu
);

  logic rn_hit;
  logic rm_hit;

  assign rn_hit = id_use_rn && idx_match(ex_rd, id_rn);
  assign rm_hit = id_use_rm && idx_match(ex_rd, id_rm);
  assign lu     = ex_valid && ex_memread && id_valid && (rn_hit || rm_hit);

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use stall/bubble insertion and a saturating bubble counter.
// Define LEGV8_WB_BYPASS_EN to forward the same-cycle write-back value into the captured operands.
module id_ex_reg
  import id_ex_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [WORD-1:0]   id_pc,
  input  logic [WORD-1:0]   id_rdata1,
  input  logic [WORD-1:0]   id_rdata2,
  input  logic [WORD-1:0]   id_imm,
  input  logic [REG_W-1:0]  id_rn,
  input  logic [REG_W-1:0]  id_rm,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_use_rn,
  input  logic              id_use_rm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_regwrite,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [WORD-1:0]   wb_data,
  output logic              ex_valid,
  output logic [WORD-1:0]   ex_pc,
  output logic [WORD-1:0]   ex_rdata1,
  output logic [WORD-1:0]   ex_rdata2,
  output logic [WORD-1:0]   ex_imm,
  output logic [REG_W-1:0]  ex_rn,
  output logic [REG_W-1:0]  ex_rm,
  output logic [REG_W-1:0]  ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              stall,
  output logic [31:0]       bubble_cnt
);

  ex_bundle_t  ex_reg;
  ex_bundle_t  ex_next;
  logic [31:0] bubble_cnt_reg;
  logic [31:0] bubble_cnt_next;
  logic        lu;

  word_t    src_data [2];
  reg_idx_t src_idx  [2];
  word_t    cap_data [2];

  hazard_detect u_hazard_detect (
    .ex_valid   (ex_reg.valid),
    .ex_memread (ex_reg.ctrl[CTRL_MEMREAD]),
    .ex_rd      (ex_reg.rd),
    .id_valid   (id_valid),
    .id_use_rn  (id_use_rn),
    .id_use_rm  (id_use_rm),
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .lu         (lu)
  );

  assign stall = lu && !flush;

  assign src_data[0] = id_rdata1;
  assign src_data[1] = id_rdata2;
  assign src_idx[0]  = id_rn;
  assign src_idx[1]  = id_rm;

  // The register file writes on the same edge we capture, so its read data is one write stale.
  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
`ifdef LEGV8_WB_BYPASS_EN
    assign cap_data[gi] = (wb_regwrite && idx_match(wb_rd, src_idx[gi])) ? wb_data : src_data[gi];
`else
    assign cap_data[gi] = src_data[gi];
`endif
  end

`ifdef LEGV8_WB_BYPASS_EN
`else
  logic unused_wb;
  assign unused_wb = ^{wb_regwrite, wb_rd, wb_data, src_idx[0], src_idx[1]};
`endif

  always_comb begin
    ex_next         = ex_reg;
    bubble_cnt_next = bubble_cnt_reg;
    if (flush) begin
      ex_next = bubble_of(ex_reg);
    end else if (hold) begin
      ex_next = ex_reg;
    end else if (lu) begin
      ex_next = bubble_of(ex_reg);
      if (bubble_cnt_reg != 32'hFFFF_FFFF) begin
        bubble_cnt_next = bubble_cnt_reg + 32'd1;
      end
    end else begin
      ex_next.valid  = id_valid;
      ex_next.pc     = id_pc;
      ex_next.rdata1 = cap_data[0];
      ex_next.rdata2 = cap_data[1];
      ex_next.imm    = id_imm;
      ex_next.rn     = id_rn;
      ex_next.rm     = id_rm;
      ex_next.rd     = id_rd;
      ex_next.ctrl   = id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_reg         <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      ex_reg         <= ex_next;
      bubble_cnt_reg <= bubble_cnt_next;
    end
  end

  assign ex_valid   = ex_reg.valid;
  assign ex_pc      = ex_reg.pc;
  assign ex_rdata1  = ex_reg.rdata1;
  assign ex_rdata2  = ex_reg.rdata2;
  assign ex_imm     = ex_reg.imm;
  assign ex_rn      = ex_reg.rn;
  assign ex_rm      = ex_reg.rm;
  assign ex_rd      = ex_reg.rd;
  assign ex_ctrl    = ex_reg.ctrl;
  assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed plus randomized check of id_ex_reg against a behavioural model of the ID/EX stage.
module tb_id_ex_reg;

`ifdef LEGV8_WB_BYPASS_EN
  localparam bit BYPASS_ON = 1'b1;
`else
  localparam bit BYPASS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, hold, id_valid;
  logic [63:0] id_pc, id_rdata1, id_rdata2, id_imm;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        id_use_rn, id_use_rm;
  logic [8:0]  id_ctrl;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        ex_valid;
  logic [63:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]  ex_rn, ex_rm, ex_rd;
  logic [8:0]  ex_ctrl;
  logic        stall;
  logic [31:0] bubble_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // Model of what EX should hold.
  bit          m_valid;
  logic [63:0] m_pc, m_r1, m_r2, m_imm;
  logic [4:0]  m_rn, m_rm, m_rd;
  logic [8:0]  m_ctrl;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold), .id_valid(id_valid),
    .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_ctrl(id_ctrl), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm(ex_imm), .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .stall(stall), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_pc = '0; m_r1 = '0; m_r2 = '0; m_imm = '0;
    m_rn = '0; m_rm = '0; m_rd = '0; m_ctrl = '0; m_cnt = '0;
  endtask

  function automatic bit model_lu();
    return m_valid && m_ctrl[1] && (m_rd != 5'd31) && id_valid &&
           ((id_use_rn && m_rd == id_rn) || (id_use_rm && m_rd == id_rm));
  endfunction

  function automatic logic [63:0] fwd(input logic [4:0] idx, input logic [63:0] raw);
    if (BYPASS_ON && wb_regwrite && wb_rd == idx && wb_rd != 5'd31) return wb_data;
    return raw;
  endfunction

  task automatic model_edge();
    bit lu;
    lu = model_lu();
    if (flush || (!hold && lu)) begin
      m_valid = 0; m_ctrl = '0; m_rd = 5'd31;
      if (!flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else if (!hold) begin
      m_valid = id_valid; m_pc = id_pc; m_imm = id_imm;
      m_r1 = fwd(id_rn, id_rdata1); m_r2 = fwd(id_rm, id_rdata2);
      m_rn = id_rn; m_rm = id_rm; m_rd = id_rd; m_ctrl = id_ctrl;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, ex_valid, m_valid);
    chk({tag, ".ctrl"}, ex_ctrl, m_ctrl);
    chk({tag, ".rd"}, ex_rd, m_rd);
    chk({tag, ".cnt"}, bubble_cnt, m_cnt);
    if (m_valid) begin
      chk({tag, ".pc"}, ex_pc, m_pc);
      chk({tag, ".r1"}, ex_rdata1, m_r1);
      chk({tag, ".r2"}, ex_rdata2, m_r2);
      chk({tag, ".imm"}, ex_imm, m_imm);
      chk({tag, ".rn"}, ex_rn, m_rn);
      chk({tag, ".rm"}, ex_rm, m_rm);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, ex_valid, 0);
    chk({tag, ".ctrl"}, ex_ctrl, 0);
    chk({tag, ".rd"}, ex_rd, 0);
    chk({tag, ".pc"}, ex_pc, 0);
    chk({tag, ".data"}, {ex_rdata1 | ex_rdata2 | ex_imm}, 0);
    chk({tag, ".rnrm"}, {ex_rn, ex_rm}, 0);
    chk({tag, ".stall"}, stall, 0);
    chk({tag, ".cnt"}, bubble_cnt, 0);
  endtask

  // Inputs are set just after an edge; stall is checked before the next edge, outputs just after.
  task automatic step(input string tag);
    #1;
    chk({tag, ".stall"}, stall, model_lu() && !flush);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic clear_inputs();
    flush = 0; hold = 0; id_valid = 0; id_pc = '0; id_rdata1 = '0; id_rdata2 = '0;
    id_imm = '0; id_rn = '0; id_rm = '0; id_rd = '0; id_use_rn = 0; id_use_rm = 0;
    id_ctrl = '0; wb_regwrite = 0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic put_id(input logic [63:0] pc, input logic [63:0] r1, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [4:0] rd, input logic [8:0] ctrl);
    id_valid = 1; id_pc = pc; id_rdata1 = r1; id_rdata2 = pc ^ 64'h55; id_imm = pc + 64'h4;
    id_rn = rn; id_rm = rm; id_rd = rd; id_use_rn = 1; id_use_rm = 1; id_ctrl = ctrl;
  endtask

  localparam logic [8:0] LDUR = 9'h01B;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    clear_inputs();
    model_reset();
    #12;
    check_zero("reset");
    rst_n = 1;

    put_id(64'h100, 64'hA, 5'd1, 5'd2, 5'd4, 9'h011);
    step("normal");
    chk("normal.pc_const", ex_pc, 64'h100);
    chk("normal.r1_const", ex_rdata1, 64'hA);
    chk("normal.ctrl_const", ex_ctrl, 9'h011);

    put_id(64'h104, 64'h0, 5'd1, 5'd2, 5'd5, LDUR);
    step("ldur");
    put_id(64'h108, 64'h7, 5'd5, 5'd6, 5'd7, 9'h001);
    #1; chk("lu.stall_const", stall, 1);
    step("lu");
    chk("lu.valid_const", ex_valid, 0);
    chk("lu.ctrl_const", ex_ctrl, 0);
    chk("lu.cnt_const", bubble_cnt, 1);
    step("lu_retry");
    chk("lu_retry.pc_const", ex_pc, 64'h108);

    put_id(64'h10C, 64'h0, 5'd1, 5'd2, 5'd31, LDUR);
    step("ldur_xzr");
    put_id(64'h110, 64'h3, 5'd31, 5'd31, 5'd8, 9'h001);
    #1; chk("xzr.stall_const", stall, 0);
    step("xzr");
    chk("xzr.valid_const", ex_valid, 1);

    put_id(64'h114, 64'h0, 5'd1, 5'd2, 5'd5, LDUR);
    step("ldur2");
    put_id(64'h118, 64'h7, 5'd5, 5'd2, 5'd9, 9'h001);
    flush = 1;
    #1; chk("flush_lu.stall_const", stall, 0);
    step("flush_lu");
    chk("flush_lu.cnt_const", bubble_cnt, 1);
    flush = 0;

    put_id(64'h11C, 64'h1, 5'd1, 5'd2, 5'd3, 9'h011);
    step("pre_hold");
    put_id(64'h120, 64'h2, 5'd1, 5'd2, 5'd3, 9'h0F1);
    hold = 1;
    step("hold");
    chk("hold.pc_const", ex_pc, 64'h11C);
    flush = 1;
    step("hold_flush");
    chk("hold_flush.ctrl_const", ex_ctrl, 0);
    flush = 0; hold = 0;

    put_id(64'h124, 64'h0, 5'd1, 5'd2, 5'd5, LDUR);
    step("ldur3");
    put_id(64'h128, 64'h7, 5'd2, 5'd5, 5'd9, 9'h001);
    hold = 1;
    #1; chk("hold_lu.stall_const", stall, 1);
    step("hold_lu");
    chk("hold_lu.ctrl_const", ex_ctrl, LDUR);
    chk("hold_lu.cnt_const", bubble_cnt, 1);
    hold = 0;
    step("hold_lu_release");

    put_id(64'h130, 64'h1, 5'd3, 5'd2, 5'd4, 9'h011);
    wb_regwrite = 1; wb_rd = 5'd3; wb_data = 64'hDEAD;
    step("bypass");
    chk("bypass.r1_const", ex_rdata1, BYPASS_ON ? 64'hDEAD : 64'h1);
    put_id(64'h134, 64'h1, 5'd31, 5'd2, 5'd4, 9'h011);
    wb_rd = 5'd31;
    step("bypass_xzr");
    chk("bypass_xzr.r1_const", ex_rdata1, 64'h1);
    wb_regwrite = 0;

    while (m_cnt < 7) begin
      put_id(64'h200, 64'h0, 5'd1, 5'd2, 5'd5, LDUR);
      step("cnt_ldur");
      put_id(64'h204, 64'h0, 5'd5, 5'd2, 5'd6, 9'h001);
      step("cnt_lu");
    end
    put_id(64'h208, 64'h9, 5'd1, 5'd2, 5'd6, 9'h011);
    step("pre_rst");
    chk("pre_rst.cnt_const", bubble_cnt, 7);
    chk("pre_rst.valid_const", ex_valid, 1);
    #2;
    rst_n = 0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    check_zero("rst_held");
    rst_n = 1;
    put_id(64'h300, 64'h5, 5'd1, 5'd2, 5'd6, 9'h011);
    step("first_after_rst");
    chk("first_after_rst.pc_const", ex_pc, 64'h300);

    for (int i = 0; i < 400; i++) begin
      id_valid    = ($urandom % 8) != 0;
      id_pc       = {$urandom, $urandom};
      id_rdata1   = {$urandom, $urandom};
      id_rdata2   = {$urandom, $urandom};
      id_imm      = {$urandom, $urandom};
      id_rn       = ($urandom % 2 == 0) ? m_rd : 5'($urandom);
      id_rm       = ($urandom % 3 == 0) ? m_rd : 5'($urandom);
      id_rd       = ($urandom % 6 == 0) ? 5'd31 : 5'($urandom % 8);
      id_use_rn   = $urandom % 2;
      id_use_rm   = $urandom % 2;
      id_ctrl     = 9'($urandom);
      id_ctrl[1]  = ($urandom % 2) != 0;
      flush       = ($urandom % 10) == 0;
      hold        = ($urandom % 8) == 0;
      wb_regwrite = $urandom % 2;
      wb_rd       = ($urandom % 2 == 0) ? id_rn : 5'($urandom);
      wb_data     = {$urandom, $urandom};
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
